// File: rtl/axi_fifo_pkg.sv
// Shared defaults, pointer-width helper and storage word layout for the
// AXI-style stream FIFO.
package axi_fifo_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 8;

   typedef struct packed {
      logic                  last;
      logic [DEF_DATA_W-1:0] data;
   } fifo_word_t;

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write port, asynchronous read port.
module fifo_ram #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage write; contents are intentionally never cleared.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/axi_stream_fifo.sv
// First-word-fall-through stream FIFO with valid/ready on both sides, a
// stored last sideband, occupancy count, threshold flags and flush.
module axi_stream_fifo
   import axi_fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int AF_LVL = DEPTH - 2,
   parameter int AE_LVL = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     wlast,
   input  logic                     wvalid,
   output logic                     wready,
   output logic [DATA_W-1:0]        rdata,
   output logic                     rlast,
   output logic                     rvalid,
   input  logic                     rready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     almost_full,
   output logic                     almost_empty
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;
   localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0] AF_CNT  = PW'(AF_LVL);
   localparam logic [PW-1:0] AE_CNT  = PW'(AE_LVL);

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } word_t;

   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          ram_we;
   word_t         wr_word;
   word_t         rd_word;

   // Wrap bit distinguishes full from empty when the index bits match.
   always_comb begin
      empty = (wptr == rptr);
      full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
   end

   assign wready = !full;
   assign rvalid = !empty;
   assign push   = wvalid && wready;
   assign pop    = rvalid && rready;
   assign count  = wptr - rptr;

   // Threshold flags follow the occupancy directly.
   always_comb begin
      almost_full  = (count >= AF_CNT);
      almost_empty = (count <= AE_CNT);
   end

   // A flush or reset cycle drops any concurrent write.
   assign ram_we  = reset && !flush && push;
   assign wr_word = '{last: wlast, data: wdata};

   fifo_ram #(
      .WIDTH ($bits(word_t)),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wptr[AW-1:0]),
      .wdata (wr_word),
      .raddr (rptr[AW-1:0]),
      .rdata (rd_word)
   );

   assign rdata = rd_word.data;
   assign rlast = rd_word.last;

   // Pointer update: reset beats flush, flush beats push/pop.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + PTR_ONE;
         end
         if (pop) begin
            rptr <= rptr + PTR_ONE;
         end
      end
   end

endmodule

// File: tb/tb_axi_stream_fifo.sv
// Directed self-checking bench for axi_stream_fifo (DATA_W=8, DEPTH=8).
module tb_axi_stream_fifo;

   logic       clk;
   logic       reset;
   logic       flush;
   logic [7:0] wdata;
   logic       wlast;
   logic       wvalid;
   logic       wready;
   logic [7:0] rdata;
   logic       rlast;
   logic       rvalid;
   logic       rready;
   logic [3:0] count;
   logic       almost_full;
   logic       almost_empty;

   int total = 0;
   int bad   = 0;

   axi_stream_fifo #(.DATA_W(8), .DEPTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .wdata        (wdata),
      .wlast        (wlast),
      .wvalid       (wvalid),
      .wready       (wready),
      .rdata        (rdata),
      .rlast        (rlast),
      .rvalid       (rvalid),
      .rready       (rready),
      .count        (count),
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_words(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         wvalid = 1'b1;
         wdata  = base + 8'(i);
         wlast  = 1'b0;
         cyc();
      end
      wvalid = 1'b0;
   endtask

   task automatic test_reset();
      total++;
      if (count !== 4'd0 || wready !== 1'b1 || rvalid !== 1'b0 ||
          almost_empty !== 1'b1 || almost_full !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: cnt=%0d wr=%b rv=%b ae=%b af=%b exp 0 1 0 1 0",
                  count, wready, rvalid, almost_empty, almost_full);
      end
      push_words(8'h01, 3);
      total++;
      if (count !== 4'd3 || rvalid !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset_fill: cnt=%0d rv=%b exp 3 1", count, rvalid);
      end
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      total++;
      if (count !== 4'd0 || wready !== 1'b1 || rvalid !== 1'b0 || almost_empty !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset: cnt=%0d wr=%b rv=%b ae=%b exp 0 1 0 1",
                  count, wready, rvalid, almost_empty);
      end
      push_words(8'h04, 3);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      total++;
      if (count !== 4'd0 || wready !== 1'b1 || rvalid !== 1'b0 || almost_empty !== 1'b1) begin
         bad++;
         $display("FAIL flush_clear: cnt=%0d wr=%b rv=%b ae=%b exp 0 1 0 1",
                  count, wready, rvalid, almost_empty);
      end
   endtask

   task automatic test_fill_drain();
      rready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (wready !== 1'b1) begin
            bad++;
            $display("FAIL fill_wready[%0d]: got %b exp 1", i, wready);
         end
         wvalid = 1'b1;
         wdata  = 8'h10 + 8'(i);
         wlast  = 1'b0;
         cyc();
      end
      total++;
      if (wready !== 1'b0 || count !== 4'd8 || almost_full !== 1'b1 || almost_empty !== 1'b0) begin
         bad++;
         $display("FAIL full_state: wr=%b cnt=%0d af=%b ae=%b exp 0 8 1 0",
                  wready, count, almost_full, almost_empty);
      end
      wdata = 8'hFF;
      cyc();
      wvalid = 1'b0;
      total++;
      if (count !== 4'd8 || rdata !== 8'h10) begin
         bad++;
         $display("FAIL overflow_ignored: cnt=%0d head=%h exp 8 10", count, rdata);
      end
      rready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (rvalid !== 1'b1 || rdata !== 8'h10 + 8'(i)) begin
            bad++;
            $display("FAIL drain[%0d]: rv=%b data=%h exp 1 %h", i, rvalid, rdata, 8'h10 + 8'(i));
         end
         cyc();
         if (i == 0) begin
            total++;
            if (wready !== 1'b1 || count !== 4'd7) begin
               bad++;
               $display("FAIL first_pop_wready: wr=%b cnt=%0d exp 1 7", wready, count);
            end
         end
      end
      rready = 1'b0;
      total++;
      if (rvalid !== 1'b0 || count !== 4'd0) begin
         bad++;
         $display("FAIL drained: rv=%b cnt=%0d exp 0 0", rvalid, count);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_q [5];
      for (int l = 0; l < 20; l++) begin
         for (int i = 0; i < 5; i++) begin
            exp_q[i] = 8'($urandom_range(0, 255));
            wvalid = 1'b1;
            wdata  = exp_q[i];
            wlast  = 1'(i == 4);
            cyc();
         end
         wvalid = 1'b0;
         rready = 1'b1;
         for (int i = 0; i < 5; i++) begin
            total++;
            if (rvalid !== 1'b1 || rdata !== exp_q[i] || rlast !== 1'(i == 4)) begin
               bad++;
               $display("FAIL wrap[%0d][%0d]: rv=%b data=%h last=%b exp 1 %h %b",
                        l, i, rvalid, rdata, rlast, exp_q[i], 1'(i == 4));
            end
            cyc();
         end
         rready = 1'b0;
         total++;
         if (count !== 4'd0) begin
            bad++;
            $display("FAIL wrap_count[%0d]: got %0d exp 0", l, count);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_d;
      push_words(8'h40, 4);
      wvalid = 1'b1;
      rready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wdata = 8'h50 + 8'(i);
         exp_d = (i < 4) ? 8'h40 + 8'(i) : 8'h50 + 8'(i - 4);
         total++;
         if (rdata !== exp_d) begin
            bad++;
            $display("FAIL b2b_data[%0d]: got %h exp %h", i, rdata, exp_d);
         end
         cyc();
         total++;
         if (count !== 4'd4) begin
            bad++;
            $display("FAIL b2b_count[%0d]: got %0d exp 4", i, count);
         end
      end
      wvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (rvalid !== 1'b1 || rdata !== 8'h56 + 8'(i)) begin
            bad++;
            $display("FAIL b2b_tail[%0d]: rv=%b data=%h exp 1 %h", i, rvalid, rdata, 8'h56 + 8'(i));
         end
         cyc();
      end
      rready = 1'b0;
      total++;
      if (rvalid !== 1'b0 || count !== 4'd0) begin
         bad++;
         $display("FAIL b2b_empty: rv=%b cnt=%0d exp 0 0", rvalid, count);
      end
   endtask

   task automatic test_sideband();
      wvalid = 1'b1;
      wdata  = 8'hA5;
      wlast  = 1'b1;
      cyc();
      wvalid = 1'b0;
      wlast  = 1'b0;
      wdata  = 8'h00;
      rready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (rvalid !== 1'b1 || rdata !== 8'hA5 || rlast !== 1'b1) begin
            bad++;
            $display("FAIL sideband_hold[%0d]: rv=%b data=%h last=%b exp 1 a5 1",
                     i, rvalid, rdata, rlast);
         end
         cyc();
      end
      rready = 1'b1;
      cyc();
      rready = 1'b0;
      total++;
      if (rvalid !== 1'b0 || count !== 4'd0) begin
         bad++;
         $display("FAIL sideband_pop: rv=%b cnt=%0d exp 0 0", rvalid, count);
      end
   endtask

   task automatic test_flush_precedence();
      push_words(8'h60, 8);
      total++;
      if (wready !== 1'b0 || count !== 4'd8) begin
         bad++;
         $display("FAIL flush_prefill: wr=%b cnt=%0d exp 0 8", wready, count);
      end
      flush  = 1'b1;
      wvalid = 1'b1;
      wdata  = 8'hEE;
      rready = 1'b1;
      cyc();
      flush  = 1'b0;
      wvalid = 1'b0;
      rready = 1'b0;
      total++;
      if (count !== 4'd0 || rvalid !== 1'b0 || wready !== 1'b1 || almost_full !== 1'b0) begin
         bad++;
         $display("FAIL flush_prec: cnt=%0d rv=%b wr=%b af=%b exp 0 0 1 0",
                  count, rvalid, wready, almost_full);
      end
      push_words(8'h77, 1);
      total++;
      if (count !== 4'd1 || rvalid !== 1'b1 || rdata !== 8'h77) begin
         bad++;
         $display("FAIL post_flush_push: cnt=%0d rv=%b data=%h exp 1 1 77", count, rvalid, rdata);
      end
   endtask

   initial begin
      reset  = 1'b0;
      flush  = 1'b0;
      wdata  = 8'h00;
      wlast  = 1'b0;
      wvalid = 1'b0;
      rready = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
      test_reset();
      test_fill_drain();
      test_wrap();
      test_back_to_back();
      test_sideband();
      test_flush_precedence();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
